tdc_stimulus_generator: RTL

// - Programmable start/stop pulse-pair source: the transmit end of the tdc start/stop interface.
// - Emits start_signal, then stop_signal a programmed interval later (coarse clk cycles + fine delay-line taps).
// - Optional burst of N pairs; each new pair waits for the TDC to finish readout (tdc_busy low).
// - Used for on-chip calibration and self-test; config comes from the SPI register file.

---
 rtl/tdc_pkg.sv | 17 +
 rtl/tdc_stimulus_generator_if.sv | 30 +++
 rtl/tdc_fine_delay_line.sv | 28 ++
 rtl/tdc_stimulus_generator.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and FSM encoding for the tdc stimulus generator and measurement block.
`timescale 1ps/1ps
package tdc_pkg;
    localparam int COARSE_W_DEF  = 32;
    localparam int FINE_TAPS_DEF = 64;
    localparam int PULSE_W_DEF   = 4;
    localparam int BURST_W_DEF   = 16;
    localparam int TIMEOUT_DEF   = 1023;
    localparam int TAP_W         = $clog2(FINE_TAPS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } tdc_state_e;
endpackage

// File: rtl/tdc_stimulus_generator_if.sv
// Config, TDC handshake and status bundle between the stimulus generator and its environment.
`timescale 1ps/1ps
interface tdc_stimulus_generator_if import tdc_pkg::*; #(
    parameter int COARSE_W  = COARSE_W_DEF,
    parameter int FINE_TAPS = FINE_TAPS_DEF,
    parameter int BURST_W   = BURST_W_DEF
);
    logic                         arm;
    logic                         abort;
    logic [COARSE_W-1:0]          coarse_delay;
    logic [$clog2(FINE_TAPS)-1:0] fine_tap;
    logic [BURST_W-1:0]           burst_count;
    logic                         tdc_busy;
    logic                         start_signal;
    logic                         stop_signal;
    logic                         gen_busy;
    logic                         done;
    logic                         timeout_err;
    logic [BURST_W-1:0]           pairs_sent;

    modport master (
        output arm, abort, coarse_delay, fine_tap, burst_count, tdc_busy,
        input  start_signal, stop_signal, gen_busy, done, timeout_err, pairs_sent
    );

    modport slave (
        input  arm, abort, coarse_delay, fine_tap, burst_count, tdc_busy,
        output start_signal, stop_signal, gen_busy, done, timeout_err, pairs_sent
    );
endinterface

// File: rtl/tdc_fine_delay_line.sv
// Inverter-pair delay chain with a tap mux; tap 0 is the undelayed input.
`timescale 1ps/1ps
module tdc_fine_delay_line import tdc_pkg::*; #(
    parameter int FINE_TAPS = FINE_TAPS_DEF
) (
    input  logic                         i_in,
    input  logic [$clog2(FINE_TAPS)-1:0] i_tap,
    output logic                         o_out
);
    logic [FINE_TAPS-1:0] w_taps;

    assign w_taps[0] = i_in;

    // Each stage keeps its own nets so the chain is not one self-referencing vector.
    for (genvar gi = 1; gi < FINE_TAPS; gi++) begin : g_stage
        (* dont_touch = "true" *) logic w_inv;
        (* dont_touch = "true" *) logic w_buf;
        if (gi == 1) begin : g_first
            assign w_inv = ~i_in;
        end else begin : g_next
            assign w_inv = ~g_stage[gi-1].w_buf;
        end
        assign w_buf      = ~w_inv;
        assign w_taps[gi] = w_buf;
    end

    assign o_out = w_taps[i_tap];
endmodule

// File: rtl/tdc_stimulus_generator.sv
// Start/stop pulse-pair source: FSM, coarse gap, pulse and TDC-wait counters, output registers.
`timescale 1ps/1ps
module tdc_stimulus_generator import tdc_pkg::*; #(
    parameter int COARSE_W  = COARSE_W_DEF,
    parameter int FINE_TAPS = FINE_TAPS_DEF,
    parameter int PULSE_W   = PULSE_W_DEF,
    parameter int BURST_W   = BURST_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tdc_stimulus_generator_if.slave  bus
);
    localparam int TW  = $clog2(FINE_TAPS);
    localparam int PCW = $clog2(PULSE_W + 1);
    localparam int WCW = $clog2(TIMEOUT + 1) + 1;

    tdc_state_e           r_state, w_next;
    logic [COARSE_W-1:0]  r_coarse, r_gap, w_coarse_ld;
    logic [TW-1:0]        r_fine;
    logic [BURST_W-1:0]   r_burst, r_pairs;
    logic [PCW-1:0]       r_start_cnt, r_stop_cnt;
    logic [WCW-1:0]       r_wait_cnt;
    logic                 r_start, r_stop_pre, r_gen_busy, r_done, r_tmo;
    logic                 r_seen, r_low;
    logic                 w_start_end, w_stop_end, w_pulses_end, w_tdc_rel, w_more, w_tmo_hit;
    logic                 w_launch, w_finish, w_tmo, w_enter_wait;

    // "_end" terms mean the pulse is low after the coming edge.
    assign w_start_end  = !r_start || (r_start_cnt == '0);
    assign w_stop_end   = (r_gap == '0) && (!r_stop_pre || (r_stop_cnt == '0));
    assign w_pulses_end = w_start_end && w_stop_end;
    assign w_tdc_rel    = !bus.tdc_busy && (r_seen || r_low);
    assign w_more       = r_pairs < r_burst;
    assign w_tmo_hit    = r_wait_cnt >= WCW'(TIMEOUT);
    assign w_coarse_ld  = (r_state == ST_IDLE) ? bus.coarse_delay : r_coarse;

    always_comb begin
        w_next       = r_state;
        w_launch     = 1'b0;
        w_finish     = 1'b0;
        w_tmo        = 1'b0;
        w_enter_wait = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.arm) begin
                    w_next   = ST_START;
                    w_launch = 1'b1;
                end
            end
            ST_START: begin
                if (w_pulses_end) begin
                    w_next       = ST_WAIT;
                    w_enter_wait = 1'b1;
                end else if (w_start_end) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_pulses_end) begin
                    w_next       = ST_WAIT;
                    w_enter_wait = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_tdc_rel) begin
                    if (w_more) begin
                        w_next   = ST_START;
                        w_launch = 1'b1;
                    end else begin
                        w_next   = ST_IDLE;
                        w_finish = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_next = ST_IDLE;
                    w_tmo  = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (bus.abort) begin
            w_next       = ST_IDLE;
            w_launch     = 1'b0;
            w_finish     = 1'b0;
            w_tmo        = 1'b0;
            w_enter_wait = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_coarse    <= '0;
            r_fine      <= '0;
            r_burst     <= '0;
            r_gap       <= '0;
            r_start     <= 1'b0;
            r_start_cnt <= '0;
            r_stop_pre  <= 1'b0;
            r_stop_cnt  <= '0;
            r_pairs     <= '0;
            r_gen_busy  <= 1'b0;
            r_done      <= 1'b0;
            r_tmo       <= 1'b0;
            r_wait_cnt  <= '0;
            r_seen      <= 1'b0;
            r_low       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_finish;
            if (bus.abort) begin
                r_start    <= 1'b0;
                r_stop_pre <= 1'b0;
                r_gap      <= '0;
                r_gen_busy <= 1'b0;
            end else if (w_launch) begin
                if (r_state == ST_IDLE) begin
                    r_coarse   <= bus.coarse_delay;
                    r_fine     <= bus.fine_tap;
                    r_burst    <= (bus.burst_count == '0) ? BURST_W'(1) : bus.burst_count;
                    r_pairs    <= '0;
                    r_gen_busy <= 1'b1;
                    r_tmo      <= 1'b0;
                end
                r_start     <= 1'b1;
                r_start_cnt <= PCW'(PULSE_W - 1);
                r_gap       <= w_coarse_ld;
                // Zero interval: stop leaves on the same edge as start.
                if (w_coarse_ld == '0) begin
                    r_stop_pre <= 1'b1;
                    r_stop_cnt <= PCW'(PULSE_W - 1);
                end
            end else begin
                if (r_start) begin
                    if (r_start_cnt == '0) r_start <= 1'b0;
                    else                   r_start_cnt <= r_start_cnt - PCW'(1);
                end
                if (r_gap == COARSE_W'(1)) begin
                    r_stop_pre <= 1'b1;
                    r_stop_cnt <= PCW'(PULSE_W - 1);
                end else if (r_stop_pre) begin
                    if (r_stop_cnt == '0) r_stop_pre <= 1'b0;
                    else                  r_stop_cnt <= r_stop_cnt - PCW'(1);
                end
                if (r_gap != '0) r_gap <= r_gap - COARSE_W'(1);
                if (w_enter_wait) begin
                    if (r_pairs != '1) r_pairs <= r_pairs + BURST_W'(1);
                    r_wait_cnt <= '0;
                    r_seen     <= 1'b0;
                    r_low      <= 1'b0;
                end else if (r_state == ST_WAIT) begin
                    if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + WCW'(1);
                    r_seen <= r_seen | bus.tdc_busy;
                    r_low  <= !bus.tdc_busy;
                end
                if (w_finish) r_gen_busy <= 1'b0;
                if (w_tmo) begin
                    r_tmo      <= 1'b1;
                    r_gen_busy <= 1'b0;
                end
            end
        end
    end

    tdc_fine_delay_line #(.FINE_TAPS(FINE_TAPS)) u_fine_dl (
        .i_in  (r_stop_pre),
        .i_tap (r_fine),
        .o_out (bus.stop_signal)
    );

    assign bus.start_signal = r_start;
    assign bus.gen_busy     = r_gen_busy;
    assign bus.done         = r_done;
    assign bus.timeout_err  = r_tmo;
    assign bus.pairs_sent   = r_pairs;
endmodule
